// File: rtl/sys_arr_out_deskew_if.sv
// Stream interface between the systolic array's skewed column outputs, the
// deskew/FIFO stage and the downstream consumer of aligned vectors.
interface sys_arr_out_deskew_if #(
    parameter int N_LANES  = 4,
    parameter int WORD_WDT = 16
);
    logic [N_LANES*WORD_WDT-1:0] in_word;
    logic [N_LANES-1:0]          in_word_val;
    logic [N_LANES*WORD_WDT-1:0] out_vec;
    logic                        out_val;
    logic                        out_rdy;

    // Array/consumer side.
    modport master (
        output in_word, in_word_val, out_rdy,
        input  out_vec, out_val
    );

    // Deskew stage side.
    modport slave (
        input  in_word, in_word_val, out_rdy,
        output out_vec, out_val
    );
endinterface

// File: rtl/sys_arr_out_deskew.sv
// Realigns skewed systolic-array column outputs into one vector and buffers
// the vectors in a first-word-fall-through FIFO that throttles the array.
module sys_arr_out_deskew #(
    parameter int N_LANES    = 4,
    parameter int WORD_WDT   = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clk_en,
    output logic                          arr_clk_en,
    sys_arr_out_deskew_if.slave           bus,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
    output logic                          err_misalign
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int VW = N_LANES * WORD_WDT;

    logic [WORD_WDT-1:0] al_word [N_LANES];
    logic [N_LANES-1:0]  al_val;
    logic [VW-1:0]       al_vec;

    logic [VW-1:0] mem_q [FIFO_DEPTH];
    logic [VW-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    logic full, wr_en, rd_en, misalign;

    // Lane i arrives i cycles after lane 0, so it waits N_LANES-1-i enabled
    // cycles; the last lane is used straight from the array.
    for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
        localparam int DEPTH = N_LANES - 1 - gi;
        if (DEPTH == 0) begin : g_pass
            assign al_word[gi] = bus.in_word[gi*WORD_WDT +: WORD_WDT];
            assign al_val[gi]  = bus.in_word_val[gi];
        end else begin : g_dly
            logic [WORD_WDT-1:0] word_q [DEPTH];
            logic [WORD_WDT-1:0] word_d [DEPTH];
            logic [DEPTH-1:0]    val_q, val_d;

            always_comb begin
                word_d = word_q;
                val_d  = val_q;
                if (arr_clk_en) begin
                    word_d[0] = bus.in_word[gi*WORD_WDT +: WORD_WDT];
                    val_d[0]  = bus.in_word_val[gi];
                    for (int k = 1; k < DEPTH; k++) begin
                        word_d[k] = word_q[k-1];
                        val_d[k]  = val_q[k-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    word_q <= '{default: '0};
                    val_q  <= '0;
                end else begin
                    word_q <= word_d;
                    val_q  <= val_d;
                end
            end

            assign al_word[gi] = word_q[DEPTH-1];
            assign al_val[gi]  = val_q[DEPTH-1];
        end
    end

    always_comb begin
        al_vec = '0;
        for (int i = 0; i < N_LANES; i++) begin
            al_vec[i*WORD_WDT +: WORD_WDT] = al_word[i];
        end
    end

    // Throttle depends only on the registered count, never on out_rdy, so a
    // pop from a full FIFO frees the slot for the following cycle.
    assign full       = (cnt_q == CW'(FIFO_DEPTH));
    assign arr_clk_en = clk_en & ~full;
    assign wr_en      = arr_clk_en & (&al_val);
    assign misalign   = arr_clk_en & (|al_val) & ~(&al_val);

    // Handshake: out_val is high whenever the FIFO holds an entry; the head
    // in out_vec is consumed on a cycle with out_val & out_rdy and stays
    // stable otherwise. out_val does not depend on out_rdy.
    assign bus.out_val = (cnt_q != '0);
    assign bus.out_vec = mem_q[rd_ptr_q];
    assign rd_en       = bus.out_val & bus.out_rdy;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        err_d    = err_q | misalign;
        if (wr_en) begin
            mem_d[wr_ptr_q] = al_vec;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({wr_en, rd_en})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage carries no reset; only pointers and count define its content.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    assign fifo_cnt     = cnt_q;
    assign err_misalign = err_q;
endmodule

// File: tb/tb_sys_arr_out_deskew.sv
// Bench for sys_arr_out_deskew: skewed-array driver, queue-based reference of
// alignment and FIFO behaviour, table rows plus hand-written corner sequences.
module tb_sys_arr_out_deskew;
    localparam int N  = 4;
    localparam int W  = 16;
    localparam int D  = 4;
    localparam int VW = N * W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic clk_en;
    logic arr_clk_en;
    logic [$clog2(D):0] fifo_cnt;
    logic err_misalign;

    always #5 clk = ~clk;

    sys_arr_out_deskew_if #(.N_LANES(N), .WORD_WDT(W)) bus ();

    sys_arr_out_deskew #(.N_LANES(N), .WORD_WDT(W), .FIFO_DEPTH(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .clk_en       (clk_en),
        .arr_clk_en   (arr_clk_en),
        .bus          (bus),
        .fifo_cnt     (fifo_cnt),
        .err_misalign (err_misalign)
    );

    // ---------------- stimulus program ----------------
    // prog_vec[k] is the column vector whose lane 0 leaves the array at
    // enabled step k; lane i of it leaves at step k+i.
    logic [VW-1:0] prog_vec  [64];
    logic [N-1:0]  prog_mask [64];
    int            prog_len;
    int            s_cnt;

    // ---------------- scoreboard / reference ----------------
    logic [VW-1:0] exp_q[$];
    logic          exp_err;
    logic          cur_en;
    logic [W-1:0]  hist_w [N][1024];
    logic          hist_v [N][1024];
    int            n_cmp = 0;
    int            n_bad = 0;

    typedef struct {
        logic       ce;
        logic       rdy;
        logic       e_val;
        logic [2:0] e_cnt;
        logic       e_en;
    } row_t;
    row_t rows [23];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic ce, input logic rdy);
        clk_en      = ce;
        bus.out_rdy = rdy;
        for (int i = 0; i < N; i++) begin
            int k;
            k = s_cnt - i;
            if (k >= 0 && k < prog_len) begin
                bus.in_word[i*W +: W] = prog_vec[k][i*W +: W];
                bus.in_word_val[i]    = prog_mask[k][i];
            end else begin
                bus.in_word[i*W +: W] = W'($urandom);
                bus.in_word_val[i]    = 1'b0;
            end
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_err = 1'b0;
        s_cnt   = 0;
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        clk_en          = 1'b1;
        bus.out_rdy     = 1'b0;
        bus.in_word     = '0;
        bus.in_word_val = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic model_check();
        cur_en = clk_en & (exp_q.size() != D);
        check("arr_clk_en", 64'(arr_clk_en), 64'(cur_en));
        check("out_val", 64'(bus.out_val), 64'(exp_q.size() != 0));
        check("fifo_cnt", 64'(fifo_cnt), 64'(exp_q.size()));
        check("err_misalign", 64'(err_misalign), 64'(exp_err));
        if (exp_q.size() != 0) check("out_vec", 64'(bus.out_vec), 64'(exp_q[0]));
    endtask

    // One clock of the reference: pop on ready, then on an enabled step record
    // what the array presented and rebuild the vector that lined up this step.
    task automatic model_step();
        logic          all_v, any_v, v;
        logic [VW-1:0] vec;
        int            idx;
        if (exp_q.size() != 0 && bus.out_rdy) void'(exp_q.pop_front());
        if (cur_en) begin
            for (int i = 0; i < N; i++) begin
                hist_w[i][s_cnt] = bus.in_word[i*W +: W];
                hist_v[i][s_cnt] = bus.in_word_val[i];
            end
            all_v = 1'b1;
            any_v = 1'b0;
            vec   = '0;
            for (int i = 0; i < N; i++) begin
                idx = s_cnt - (N - 1 - i);
                v   = 1'b0;
                if (idx >= 0) begin
                    v = hist_v[i][idx];
                    vec[i*W +: W] = hist_w[i][idx];
                end
                all_v &= v;
                any_v |= v;
            end
            if (all_v) exp_q.push_back(vec);
            else if (any_v) exp_err = 1'b1;
            s_cnt++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic ce, input logic rdy);
        drive(ce, rdy);
        @(negedge clk);
        model_check();
        model_step();
        tick();
    endtask

    task automatic run_table(input int lo, input int hi);
        for (int r = lo; r <= hi; r++) begin
            drive(rows[r].ce, rows[r].rdy);
            @(negedge clk);
            check($sformatf("tbl%0d_val", r), 64'(bus.out_val), 64'(rows[r].e_val));
            check($sformatf("tbl%0d_cnt", r), 64'(fifo_cnt), 64'(rows[r].e_cnt));
            check($sformatf("tbl%0d_en", r), 64'(arr_clk_en), 64'(rows[r].e_en));
            if (r == 4) check("tbl_vec_a", 64'(bus.out_vec), 64'h0004_0003_0002_0001);
            model_check();
            model_step();
            tick();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // ---------------- test sequence ----------------
    initial begin
        logic ce_pat [8];
        // single vector A, out_rdy=1: head appears once, one cycle after lane 3
        rows[0]  = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b1};
        rows[1]  = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b1};
        rows[2]  = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b1};
        rows[3]  = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b1};
        rows[4]  = '{1'b1, 1'b1, 1'b1, 3'd1, 1'b1};
        rows[5]  = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b1};
        rows[6]  = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b1};
        // six vectors into a depth-4 FIFO, consumer blocked then released
        rows[7]  = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b1};
        rows[8]  = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b1};
        rows[9]  = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b1};
        rows[10] = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b1};
        rows[11] = '{1'b1, 1'b0, 1'b1, 3'd1, 1'b1};
        rows[12] = '{1'b1, 1'b0, 1'b1, 3'd2, 1'b1};
        rows[13] = '{1'b1, 1'b0, 1'b1, 3'd3, 1'b1};
        rows[14] = '{1'b1, 1'b0, 1'b1, 3'd4, 1'b0};
        rows[15] = '{1'b1, 1'b0, 1'b1, 3'd4, 1'b0};
        rows[16] = '{1'b1, 1'b1, 1'b1, 3'd4, 1'b0};
        rows[17] = '{1'b1, 1'b1, 1'b1, 3'd3, 1'b1};
        rows[18] = '{1'b1, 1'b1, 1'b1, 3'd3, 1'b1};
        rows[19] = '{1'b1, 1'b1, 1'b1, 3'd3, 1'b1};
        rows[20] = '{1'b1, 1'b1, 1'b1, 3'd2, 1'b1};
        rows[21] = '{1'b1, 1'b1, 1'b1, 3'd1, 1'b1};
        rows[22] = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b1};

        prog_len = 0;
        model_reset();
        do_reset();

        // test 1
        prog_len     = 1;
        prog_vec[0]  = 64'h0004_0003_0002_0001;
        prog_mask[0] = 4'hF;
        do_reset();
        run_table(0, 6);

        // tests 2 and 3
        prog_len = 6;
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < N; i++) prog_vec[k][i*W +: W] = W'((k + 1) * 256 + i + 1);
            prog_mask[k] = 4'hF;
        end
        do_reset();
        run_table(7, 22);

        // test 4: lane 2 withheld on vector 1
        prog_len = 3;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < N; i++) prog_vec[k][i*W +: W] = W'(16'h4000 + k * 16 + i);
            prog_mask[k] = 4'hF;
        end
        prog_mask[1] = 4'b1011;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            drive(1'b1, 1'b0);
            @(negedge clk);
            if (c == 4) check("t4_err_before", 64'(err_misalign), 64'd0);
            if (c == 5) check("t4_err_set", 64'(err_misalign), 64'd1);
            if (c == 5) check("t4_no_write", 64'(fifo_cnt), 64'd1);
            if (c == 7) check("t4_err_sticky", 64'(err_misalign), 64'd1);
            if (c == 7) check("t4_good_written", 64'(fifo_cnt), 64'd2);
            model_check();
            model_step();
            tick();
        end

        // test 5: clk_en 1,0,0,1 in the middle of the skew
        prog_len     = 1;
        prog_vec[0]  = 64'hA004_A003_A002_A001;
        prog_mask[0] = 4'hF;
        ce_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        do_reset();
        for (int c = 0; c < 8; c++) begin
            drive(ce_pat[c], 1'b1);
            @(negedge clk);
            if (c == 4 || c == 5) check("t5_not_early", 64'(bus.out_val), 64'd0);
            if (c == 6) check("t5_val", 64'(bus.out_val), 64'd1);
            if (c == 6) check("t5_vec", 64'(bus.out_vec), 64'hA004_A003_A002_A001);
            if (c == 7) check("t5_one_shot", 64'(bus.out_val), 64'd0);
            model_check();
            model_step();
            tick();
        end

        // test 6: reset with three stored vectors and two in flight
        prog_len = 5;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < N; i++) prog_vec[k][i*W +: W] = W'(16'h6000 + k * 16 + i);
            prog_mask[k] = 4'hF;
        end
        do_reset();
        for (int c = 0; c < 6; c++) cyc(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        @(negedge clk);
        check("t6_pre_cnt", 64'(fifo_cnt), 64'd3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        prog_len = 0;
        drive(1'b1, 1'b1);
        @(negedge clk);
        check("t6_val", 64'(bus.out_val), 64'd0);
        check("t6_cnt", 64'(fifo_cnt), 64'd0);
        check("t6_err", 64'(err_misalign), 64'd0);
        check("t6_en", 64'(arr_clk_en), 64'd1);
        model_check();
        model_step();
        tick();
        for (int c = 0; c < 8; c++) cyc(1'b1, 1'b1);

        // randomized rounds against the reference
        for (int rnd = 0; rnd < 4; rnd++) begin
            prog_len = 40;
            for (int k = 0; k < 40; k++) begin
                for (int i = 0; i < N; i++) prog_vec[k][i*W +: W] = W'($urandom);
                prog_mask[k] = ($urandom_range(0, 9) == 0) ? N'($urandom) : 4'hF;
            end
            do_reset();
            for (int c = 0; c < 150; c++) begin
                cyc(($urandom_range(0, 4) != 0), ($urandom_range(0, 2) != 0));
            end
        end

        // ---------------- final report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
